// File: rtl/study_session_timer_pkg.sv
// Shared types and helpers for the motion-aware study/break timer.
// Optional feature macro used by the top level: STUDY_TIMER_AUTO_REPEAT_EN.
package study_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STUDY  = 2'd1,
        PAUSED = 2'd2,
        BREAK  = 2'd3
    } state_t;

    // MM:SS as four BCD digits, M1 in the top nibble.
    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    localparam bcd_time_t BCD_ZERO = '0;

    // Seconds to MM:SS BCD; only ever evaluated on parameters.
    function automatic bcd_time_t sec_to_bcd(input int seconds);
        int mm;
        int ss;
        bcd_time_t r;
        mm   = seconds / 60;
        ss   = seconds % 60;
        r.m1 = 4'(mm / 10);
        r.m0 = 4'(mm % 10);
        r.s1 = 4'(ss / 10);
        r.s0 = 4'(ss % 10);
        return r;
    endfunction

endpackage

// File: rtl/study_session_timer_if.sv
// Control/status bundle between the timer and its neighbours
// (motion classifier, seven-segment driver, UART status path).
interface study_session_timer_if;
    import study_timer_pkg::*;

    logic        moving;
    logic        start;
    logic [15:0] time_bcd;
    state_t      state;
    logic        study_done;
    logic        break_done;

    modport master (
        output moving, start,
        input  time_bcd, state, study_done, break_done
    );

    modport slave (
        input  moving, start,
        output time_bcd, state, study_done, break_done
    );

endinterface

// File: rtl/bcd_mmss_down_counter.sv
// Loadable MM:SS BCD down-counter that sticks at 00:00 and flags 00:01.
module bcd_mmss_down_counter
    import study_timer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  bcd_time_t load_val_i,
    input  logic      dec_i,
    output bcd_time_t value_o,
    output logic      is_one_o
);

    bcd_time_t value_q;
    bcd_time_t value_d;
    bcd_time_t dec_val;

    // One-second decrement with digit borrows; 00:00 is never decremented.
    always_comb begin
        dec_val = value_q;
        if (value_q != BCD_ZERO) begin
            if (value_q.s0 != 4'd0) begin
                dec_val.s0 = value_q.s0 - 4'd1;
            end else begin
                dec_val.s0 = 4'd9;
                if (value_q.s1 != 4'd0) begin
                    dec_val.s1 = value_q.s1 - 4'd1;
                end else begin
                    dec_val.s1 = 4'd5;
                    if (value_q.m0 != 4'd0) begin
                        dec_val.m0 = value_q.m0 - 4'd1;
                    end else begin
                        dec_val.m0 = 4'd9;
                        dec_val.m1 = value_q.m1 - 4'd1;
                    end
                end
            end
        end
    end

    // Load takes precedence over decrement.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (dec_i) begin
            value_d = dec_val;
        end
    end

    // Value register.
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign is_one_o = (value_q == 16'h0001);

endmodule

// File: rtl/study_session_timer.sv
// Study/break countdown with motion-qualified pause and resume.
// Prescaler, motion qualifier and FSM live here; the BCD arithmetic is in
// bcd_mmss_down_counter.
// Macro STUDY_TIMER_AUTO_REPEAT_EN: when defined, break expiry starts a new
// study period instead of returning to IDLE.
module study_session_timer
    import study_timer_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int STUDY_SECONDS = 1500,
    parameter int BREAK_SECONDS = 300,
    parameter int MOVE_HOLD     = 3
) (
    input logic                  clk,
    input logic                  rst,
    study_session_timer_if.slave bus
);

    localparam int             PW        = $clog2(CLK_HZ + 1);
    localparam logic [PW-1:0]  PRE_MAX   = PW'(CLK_HZ - 1);
    localparam logic [3:0]     HOLD      = 4'(MOVE_HOLD);
    localparam bcd_time_t      STUDY_BCD = sec_to_bcd(STUDY_SECONDS);
    localparam bcd_time_t      BREAK_BCD = sec_to_bcd(BREAK_SECONDS);

    logic [PW-1:0] pre_q, pre_d;
    logic          sec_tick;
    logic [3:0]    move_run_q, move_run_d, move_inc;
    logic [3:0]    still_run_q, still_run_d, still_inc;
    logic          move_hit, still_hit;
    state_t        state_q, state_d;
    logic          study_done_q, study_done_d;
    logic          break_done_q, break_done_d;
    logic          cnt_load, cnt_dec, cnt_is_one;
    bcd_time_t     cnt_load_val, cnt_val;

    assign sec_tick = (pre_q == PRE_MAX);

    // Prescaler restarts on start so the first second is a full one.
    always_comb begin
        pre_d = pre_q + PW'(1);
        if (bus.start || sec_tick) begin
            pre_d = '0;
        end
    end

    // Saturating run lengths as they would be after this tick.
    assign move_inc  = !bus.moving ? 4'd0 : (move_run_q == HOLD) ? HOLD : move_run_q + 4'd1;
    assign still_inc = bus.moving  ? 4'd0 : (still_run_q == HOLD) ? HOLD : still_run_q + 4'd1;
    assign move_hit  = sec_tick && (move_inc == HOLD);
    assign still_hit = sec_tick && (still_inc == HOLD);

    // Next state and counter control; priority start > expiry > motion.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        study_done_d = 1'b0;
        break_done_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = STUDY_BCD;
        cnt_dec      = 1'b0;
        if (bus.start) begin
            state_d  = STUDY;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                STUDY: begin
                    if (sec_tick) begin
                        if (cnt_is_one) begin
                            state_d      = BREAK;
                            cnt_load     = 1'b1;
                            cnt_load_val = BREAK_BCD;
                            study_done_d = 1'b1;
                        end else begin
                            cnt_dec = 1'b1;
                            if (move_hit) begin
                                state_d = PAUSED;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (still_hit) begin
                        state_d = STUDY;
                    end
                end
                BREAK: begin
                    if (sec_tick) begin
                        if (cnt_is_one) begin
                            break_done_d = 1'b1;
                            cnt_load     = 1'b1;
`ifdef STUDY_TIMER_AUTO_REPEAT_EN
                            state_d      = STUDY;
                            cnt_load_val = STUDY_BCD;
`else
                            state_d      = IDLE;
                            cnt_load_val = BCD_ZERO;
`endif
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Motion qualifier: cleared on start or any state change, else tick-updated.
    always_comb begin
        move_run_d  = move_run_q;
        still_run_d = still_run_q;
        if (bus.start || (state_d != state_q)) begin
            move_run_d  = 4'd0;
            still_run_d = 4'd0;
        end else if (sec_tick) begin
            move_run_d  = move_inc;
            still_run_d = still_inc;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            move_run_q   <= 4'd0;
            still_run_q  <= 4'd0;
            state_q      <= IDLE;
            study_done_q <= 1'b0;
            break_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            move_run_q   <= move_run_d;
            still_run_q  <= still_run_d;
            state_q      <= state_d;
            study_done_q <= study_done_d;
            break_done_q <= break_done_d;
        end
    end

    bcd_mmss_down_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .value_o    (cnt_val),
        .is_one_o   (cnt_is_one)
    );

    assign bus.time_bcd   = cnt_val;
    assign bus.state      = state_q;
    assign bus.study_done = study_done_q;
    assign bus.break_done = break_done_q;

endmodule

// File: tb/tb_study_session_timer.sv
// Bench for study_session_timer: directed scenarios plus a randomized run
// against a seconds-based reference model. Honours STUDY_TIMER_AUTO_REPEAT_EN.
module tb_study_session_timer;
    import study_timer_pkg::*;

    localparam int CLK_HZ    = 10;
    localparam int STUDY_S   = 5;
    localparam int BREAK_S   = 3;
    localparam int HOLD      = 2;

    typedef struct {
        int          wait_cycles;
        logic [19:0] exp;
        string       name;
    } step_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    study_session_timer_if bus ();
    study_session_timer_if bus600 ();

    study_session_timer #(
        .CLK_HZ(CLK_HZ), .STUDY_SECONDS(STUDY_S), .BREAK_SECONDS(BREAK_S), .MOVE_HOLD(HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    study_session_timer #(
        .CLK_HZ(CLK_HZ), .STUDY_SECONDS(600), .BREAK_SECONDS(BREAK_S), .MOVE_HOLD(HOLD)
    ) dut_600 (
        .clk (clk),
        .rst (rst),
        .bus (bus600)
    );

    // {state, study_done, break_done, time_bcd}
    logic [19:0] obs, obs600;
    assign obs    = {bus.state, bus.study_done, bus.break_done, bus.time_bcd};
    assign obs600 = {bus600.state, bus600.study_done, bus600.break_done, bus600.time_bcd};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    // Reference model: remaining time kept as plain seconds.
    int m_state, m_rem, m_pre, m_move, m_still;
    bit m_sd, m_bd;

    always @(posedge clk) begin : ref_model
        int st, rem, pre, mv, sl, nmv, nsl, prev;
        bit sd, bd, tick;
        st = m_state; rem = m_rem; pre = m_pre; mv = m_move; sl = m_still;
        sd = 1'b0; bd = 1'b0;
        if (rst) begin
            st = 0; rem = 0; pre = 0; mv = 0; sl = 0;
        end else begin
            tick = (pre == CLK_HZ - 1);
            pre  = (bus.start || tick) ? 0 : pre + 1;
            if (bus.start) begin
                st = 1; rem = STUDY_S; mv = 0; sl = 0;
            end else if (tick) begin
                nmv  = bus.moving ? ((mv + 1 > HOLD) ? HOLD : mv + 1) : 0;
                nsl  = !bus.moving ? ((sl + 1 > HOLD) ? HOLD : sl + 1) : 0;
                prev = st;
                if (st == 1) begin
                    if (rem == 1) begin
                        rem = BREAK_S; st = 3; sd = 1'b1;
                    end else begin
                        if (rem > 0) rem = rem - 1;
                        if (nmv == HOLD) st = 2;
                    end
                end else if (st == 2) begin
                    if (nsl == HOLD) st = 1;
                end else if (st == 3) begin
                    if (rem == 1) begin
                        bd = 1'b1;
`ifdef STUDY_TIMER_AUTO_REPEAT_EN
                        st = 1; rem = STUDY_S;
`else
                        st = 0; rem = 0;
`endif
                    end else if (rem > 0) begin
                        rem = rem - 1;
                    end
                end
                if (st != prev) begin
                    mv = 0; sl = 0;
                end else begin
                    mv = nmv; sl = nsl;
                end
            end
        end
        m_state <= st; m_rem <= rem; m_pre <= pre; m_move <= mv; m_still <= sl;
        m_sd <= sd; m_bd <= bd;
    end

    task automatic do_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.moving = 1'b0;
        bus600.start = 1'b0; bus600.moving = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the caller at the negedge right after start is accepted.
    task automatic pulse_start;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        step_t steps[$];
        rst = 1'b1;
        bus.start = 1'b0; bus.moving = 1'b0;
        bus600.start = 1'b0; bus600.moving = 1'b0;
        steps = '{'{2, 20'h0_0000, "reset_state"}};
        foreach (steps[i]) begin
            repeat (steps[i].wait_cycles) @(negedge clk);
            checks++;
            if (obs !== steps[i].exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", steps[i].name, obs, steps[i].exp);
            end
        end
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (obs !== 20'h0_0000) begin
            errors++;
            $display("FAIL idle_no_start: got %h expected %h", obs, 20'h0_0000);
        end
    endtask

    task automatic test_countdown;
        step_t steps[$];
        do_reset();
        pulse_start();
        steps = '{
            '{0,  {2'd1, 2'b00, 16'h0005}, "load_study"},
            '{9,  {2'd1, 2'b00, 16'h0005}, "before_first_tick"},
            '{1,  {2'd1, 2'b00, 16'h0004}, "tick_0004"},
            '{10, {2'd1, 2'b00, 16'h0003}, "tick_0003"},
            '{10, {2'd1, 2'b00, 16'h0002}, "tick_0002"},
            '{10, {2'd1, 2'b00, 16'h0001}, "tick_0001"},
            '{10, {2'd3, 2'b10, 16'h0003}, "study_expiry"},
            '{1,  {2'd3, 2'b00, 16'h0003}, "study_done_one_cycle"},
            '{9,  {2'd3, 2'b00, 16'h0002}, "break_0002"},
            '{10, {2'd3, 2'b00, 16'h0001}, "break_0001"},
`ifdef STUDY_TIMER_AUTO_REPEAT_EN
            '{10, {2'd1, 2'b01, 16'h0005}, "break_expiry_repeat"},
            '{1,  {2'd1, 2'b00, 16'h0005}, "break_done_one_cycle"}
`else
            '{10, {2'd0, 2'b01, 16'h0000}, "break_expiry_idle"},
            '{1,  {2'd0, 2'b00, 16'h0000}, "break_done_one_cycle"}
`endif
        };
        foreach (steps[i]) begin
            repeat (steps[i].wait_cycles) @(negedge clk);
            checks++;
            if (obs !== steps[i].exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", steps[i].name, obs, steps[i].exp);
            end
        end
    endtask

    task automatic test_motion_pause;
        step_t steps[$];
        do_reset();
        pulse_start();
        bus.moving = 1'b1;
        steps = '{
            '{10, {2'd1, 2'b00, 16'h0004}, "motion_first_tick"},
            '{10, {2'd2, 2'b00, 16'h0003}, "motion_paused"},
            '{30, {2'd2, 2'b00, 16'h0003}, "paused_holds"}
        };
        foreach (steps[i]) begin
            repeat (steps[i].wait_cycles) @(negedge clk);
            checks++;
            if (obs !== steps[i].exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", steps[i].name, obs, steps[i].exp);
            end
        end
        bus.moving = 1'b0;
        steps = '{
            '{10, {2'd2, 2'b00, 16'h0003}, "resume_wait"},
            '{10, {2'd1, 2'b00, 16'h0003}, "resume_study"},
            '{10, {2'd1, 2'b00, 16'h0002}, "resume_decrement"}
        };
        foreach (steps[i]) begin
            repeat (steps[i].wait_cycles) @(negedge clk);
            checks++;
            if (obs !== steps[i].exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", steps[i].name, obs, steps[i].exp);
            end
        end
    endtask

    task automatic test_break_motion;
        step_t steps[$];
        do_reset();
        pulse_start();
        repeat (50) @(negedge clk);
        checks++;
        if (obs !== {2'd3, 2'b10, 16'h0003}) begin
            errors++;
            $display("FAIL enter_break: got %h expected %h", obs, {2'd3, 2'b10, 16'h0003});
        end
        bus.moving = 1'b1;
        steps = '{
            '{10, {2'd3, 2'b00, 16'h0002}, "break_moving_0002"},
            '{10, {2'd3, 2'b00, 16'h0001}, "break_moving_0001"},
`ifdef STUDY_TIMER_AUTO_REPEAT_EN
            '{10, {2'd1, 2'b01, 16'h0005}, "break_moving_expiry"}
`else
            '{10, {2'd0, 2'b01, 16'h0000}, "break_moving_expiry"}
`endif
        };
        foreach (steps[i]) begin
            repeat (steps[i].wait_cycles) @(negedge clk);
            checks++;
            if (obs !== steps[i].exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", steps[i].name, obs, steps[i].exp);
            end
        end
        bus.moving = 1'b0;
    endtask

    task automatic test_restart;
        step_t steps[$];
        do_reset();
        pulse_start();
        bus.moving = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (obs !== {2'd2, 2'b00, 16'h0003}) begin
            errors++;
            $display("FAIL restart_paused: got %h expected %h", obs, {2'd2, 2'b00, 16'h0003});
        end
        repeat (5) @(negedge clk);
        bus.moving = 1'b0;
        pulse_start();
        steps = '{
            '{0, {2'd1, 2'b00, 16'h0005}, "restart_load"},
            '{9, {2'd1, 2'b00, 16'h0005}, "restart_full_second"},
            '{1, {2'd1, 2'b00, 16'h0004}, "restart_first_tick"}
        };
        foreach (steps[i]) begin
            repeat (steps[i].wait_cycles) @(negedge clk);
            checks++;
            if (obs !== steps[i].exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", steps[i].name, obs, steps[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        pulse_start();
        repeat (55) @(negedge clk);
        checks++;
        if (obs !== {2'd3, 2'b00, 16'h0003}) begin
            errors++;
            $display("FAIL mid_break: got %h expected %h", obs, {2'd3, 2'b00, 16'h0003});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 20'h0_0000) begin
            errors++;
            $display("FAIL reset_mid_break: got %h expected %h", obs, 20'h0_0000);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (obs !== 20'h0_0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, 20'h0_0000);
        end
    endtask

    task automatic test_ten_minute;
        step_t steps[$];
        do_reset();
        bus600.start = 1'b1;
        @(negedge clk);
        bus600.start = 1'b0;
        steps = '{
            '{0,  {2'd1, 2'b00, 16'h1000}, "load_1000"},
            '{10, {2'd1, 2'b00, 16'h0959}, "borrow_0959"},
            '{10, {2'd1, 2'b00, 16'h0958}, "after_borrow_0958"}
        };
        foreach (steps[i]) begin
            repeat (steps[i].wait_cycles) @(negedge clk);
            checks++;
            if (obs600 !== steps[i].exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", steps[i].name, obs600, steps[i].exp);
            end
        end
    endtask

    task automatic test_random;
        logic [19:0] exp;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            exp = {m_state[1:0], m_sd, m_bd, to_bcd(m_rem)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h expected %h", c, obs, exp);
            end
            if (bus.moving ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 39) == 0))
                bus.moving = ~bus.moving;
            bus.start = ($urandom_range(0, 299) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_countdown();
        test_motion_pause();
        test_break_motion();
        test_restart();
        test_reset_mid();
        test_ten_minute();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/study_session_timer.md
# study_session_timer

Downstream consumer of the motion classifier's `moving` flag in the motion-aware study timer. It runs a study/break countdown in BCD MM:SS. The study countdown pauses only after motion has persisted for a qualifying number of whole seconds, and resumes after stillness has persisted for the same time. Its `time_bcd` output feeds the seven-segment driver's `value` input; `state` and the event pulses feed the UART status path.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency; the prescaler divides by this value.
- `STUDY_SECONDS`, default 1500: study period length; legal range 1..5999.
- `BREAK_SECONDS`, default 300: break period length; legal range 1..5999.
- `MOVE_HOLD`, default 3: consecutive seconds of motion or stillness needed to pause or resume; legal range 1..15.
- `clk` input 1: system clock.
- `rst` input 1: reset. Synchronous, active-high.
- `moving` input 1: motion flag from the classifier. Level signal, already synchronous to `clk`.
- `start` input 1: one-cycle pulse that starts or restarts a study period.
- `time_bcd` output 16: remaining time as 4 BCD digits M1 M0 S1 S0 (`[15:12]` down to `[3:0]`).
- `state` output 2: current state. 0 IDLE, 1 STUDY, 2 PAUSED, 3 BREAK.
- `study_done` output 1: one-cycle pulse when a study period expires.
- `break_done` output 1: one-cycle pulse when a break period expires.

## Operation
- **Prescaler**
  - Counts 0..CLK_HZ-1.
  - `sec_tick` is internal and high for the single cycle in which the count equals CLK_HZ-1.
  - The prescaler is cleared by `rst` and by an accepted `start`, so the first second after `start` is a full second.
- **Motion qualifier**
  - Updated only on `sec_tick`.
  - `move_run`: increments (saturating at MOVE_HOLD) if `moving`=1 at the tick, otherwise clears to 0.
  - `still_run`: the mirror of `move_run` for `moving`=0.
  - Both counters clear on `start` and on every state change.
- **States**
  - IDLE: `time_bcd`=0000. On `start`: load STUDY_SECONDS and go to STUDY.
  - STUDY: decrement by one second on each `sec_tick`.
    - If the tick occurs at 00:01: load BREAK_SECONDS, go to BREAK, pulse `study_done`.
    - Otherwise, if `move_run` reaches MOVE_HOLD at this tick: go to PAUSED, with time frozen at its value after this tick's decrement.
  - PAUSED: time frozen. When `still_run` reaches MOVE_HOLD at a tick: go to STUDY. No decrement happens on that tick.
  - BREAK: decrement on each tick regardless of `moving`. At 00:01: pulse `break_done` and go to IDLE (see Configuration).
  - `start` in any non-IDLE state restarts: load STUDY_SECONDS, go to STUDY, no done pulse.
- **BCD arithmetic**
  - S0 decrements; borrow at 0 sets S0=9.
  - S1 decrements; borrow at 0 sets S1=5.
  - M0 decrements; borrow at 0 sets M0=9, then M1 decrements.
  - 00:00 is never decremented.
  - Load values are converted from seconds to BCD at elaboration: mm=S/60, ss=S%60.
- **Priority within one cycle:** `rst` > `start` > expiry > motion qualification.

## Timing
- All outputs are registered.
- Reset values: `time_bcd`=16'h0000, `state`=IDLE, `study_done`=0, `break_done`=0. Prescaler, `move_run` and `still_run` are 0.
- `start` accepted in cycle N: `state`=STUDY and `time_bcd`=load value visible in cycle N+1.
- The first decrement happens CLK_HZ cycles after `start`.
- Each decrement or transition is visible in the cycle after the `sec_tick` cycle.
- A done pulse is coincident with the new state and the new load value, and lasts exactly one cycle.
- Pause latency: motion raised just before a tick pauses after exactly MOVE_HOLD ticks.
- `rst` mid-operation returns all outputs to reset values on the next edge; no done pulse is emitted.

## Configuration
- Macro: `STUDY_TIMER_AUTO_REPEAT_EN`.
- Defined: BREAK expiry loads STUDY_SECONDS and goes to STUDY (pulsing `break_done`), so the study/break cycle repeats indefinitely.
- Undefined: BREAK expiry goes to IDLE with `time_bcd`=0000, also pulsing `break_done`.

## Structure
- Package `study_timer_pkg` contains:
  - `state_t` enum (IDLE, STUDY, PAUSED, BREAK; 2 bits, encodings as above).
  - `bcd_time_t` packed struct of four 4-bit digits.
  - Function `sec_to_bcd(int)` returning `bcd_time_t`.
- One sub-module, `bcd_mmss_down_counter`. It provides load, decrement enable, the current value, and an `is_one` flag (value equals 00:01).
- The FSM, prescaler and qualifier stay in the top-level module.

## Test plan
All scenarios use CLK_HZ=10, STUDY_SECONDS=5, BREAK_SECONDS=3, MOVE_HOLD=2.
- **Reset then start, `moving`=0:**
  - `time_bcd` reads 0005, 0004, … 0001 at 10-cycle intervals.
  - Then 0003 with `study_done` high for 1 cycle and `state`=BREAK.
  - After 3 more ticks: `break_done` pulses and `state`=IDLE.
- **Motion during STUDY:**
  - `moving`=1 from start+1 cycle pauses after 2 ticks with `time_bcd`=0003, and time holds.
  - Dropping `moving` resumes STUDY after 2 ticks at 0003.
- **Motion during BREAK:** `moving`=1 throughout; the countdown is unaffected.
- **Restart:** `start` while PAUSED at 0003 gives STUDY at 0005 next cycle, no done pulse; the next decrement comes 10 cycles later.
- **Reset mid-operation:** `rst` in BREAK gives all outputs 0 and IDLE next cycle.
- **Macro and 10-minute borrow:**
  - With `STUDY_TIMER_AUTO_REPEAT_EN`, BREAK expiry gives `state`=STUDY and `time_bcd`=0005.
  - Separately, with STUDY_SECONDS=600, the first tick gives 0959.
